prog_load_ctrl: RTL and testbench
=================================

Name: prog_load_ctrl

Overview:
- Boot-time controller that fills the 16-bit program memory from the SPART receive byte stream.
- Holds the CPU (cpu_hold) while loading, writes each assembled word at sequential byte-aligned addresses, then releases the CPU.
- Reports the outcome with an ACK/NAK byte on the SPART transmit side.
- Sits between the SPART rx/tx interface, the program memory write port, and the CPU reset/stall logic.

Parameters:
- ADDR_WIDTH, 16, program memory byte-address width; word index is addr[ADDR_WIDTH-1:1]
- BASE_ADDR, 16'h0000, byte address of the first loaded word; must be even
- SYNC_BYTE, 8'hA5, frame start marker
- TIMEOUT_CYCLES, 1000000, maximum idle clocks between bytes inside a frame

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from SPART
- rx_valid  in  1  one-cycle strobe; rx_data valid
- tx_data  out  8  status byte to SPART
- tx_req  out  1  tx_data valid; held until accepted
- tx_rdy  in  1  SPART accepts the byte when tx_req & tx_rdy
- mem_addr  out  ADDR_WIDTH  byte address of write (LSB always 0)
- mem_wdata  out  16  word to write
- mem_we  out  1  one-cycle write strobe
- cpu_hold  out  1  high: CPU held in reset/stall
- load_done  out  1  high after a successful frame
- load_err  out  1  high after a failed frame
- words_loaded  out  ADDR_WIDTH  count of words written in the current/last frame

Behaviour:
- Reset (async, rst_n low): state IDLE; cpu_hold=1; mem_we=0; tx_req=0; tx_data=0; load_done=0; load_err=0; words_loaded=0; mem_addr=BASE_ADDR; mem_wdata=0.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO (N words, big-endian), then N×{DATA_HI, DATA_LO}, then CHK only when the optional feature is enabled.
- State machine, each transition on rx_valid:
  - IDLE: SYNC_BYTE -> LEN_HI; any other byte is ignored.
  - LEN_HI -> LEN_LO.
  - LEN_LO:
    - N > 2**(ADDR_WIDTH-1) - BASE_ADDR/2 -> ERR.
    - N == 0 -> CHK if CHECKSUM_EN, else DONE.
    - otherwise -> DATA_HI.
  - DATA_HI: latch high byte -> DATA_LO.
  - DATA_LO: register the word. The cycle after the low byte's rx_valid: mem_we=1, mem_wdata={hi,lo}, mem_addr=BASE_ADDR+2*k for k-th word (k from 0). words_loaded increments in the same cycle. Last word -> CHK/DONE; otherwise -> DATA_HI.
  - DONE: cpu_hold=0, load_done=1, load_err=0.
  - ERR: cpu_hold=1, load_err=1, load_done=0.
- Entering DONE sends 8'h06; entering ERR sends 8'h15. tx_req rises on entry and clears in the cycle after tx_req&tx_rdy. Exactly one byte is sent per entry.
- Restart: in DONE or ERR, SYNC_BYTE re-enters LEN_HI. This sets cpu_hold=1, clears load_done, load_err and words_loaded, and resets the address to BASE_ADDR. A pending tx byte is still completed.
- Timeout: idle counter clears on every rx_valid and counts in LEN_HI..CHK. Reaching TIMEOUT_CYCLES-1 goes to ERR. It does not count in IDLE, DONE or ERR.
- Write back-to-back: rx_valid on the cycle mem_we is high is accepted normally; no stall path exists.
- Address arithmetic: ADDR_WIDTH wide; the length check guarantees no wrap.
- rx_valid held high for multiple cycles counts as multiple bytes; SPART guarantees single-cycle strobes.

Optional Feature:
- Macro: PROG_LOAD_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator over LEN_HI, LEN_LO and all data bytes clears on SYNC_BYTE.
  - The CHK state compares the received byte with the accumulator: match -> DONE, mismatch -> ERR.
  - Words already written stay in memory, but the CPU stays held.
- Undefined: no accumulator and no CHK state; the last DATA_LO (or N==0) goes directly to DONE.

Decomposition:
- Package prog_load_pkg:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHK, DONE, ERR)
  - constants ACK_BYTE=8'h06, NAK_BYTE=8'h15, default SYNC_BYTE
- Sub-module prog_load_timeout: an idle counter with clear/enable inputs and an expired output. This is a natural split; the rest stays flat.

Test Plan:
- Reset with rst_n low mid-frame (after 1 data byte) -> cpu_hold=1, no mem_we, IDLE; a subsequent full frame loads from BASE_ADDR.
- Frame A5 00 02 12 34 AB CD -> mem_we at 16'h0000 data 16'h1234, then at 16'h0002 data 16'hABCD; words_loaded=2; load_done=1; cpu_hold=0; tx byte 06 sent once with tx_rdy delayed 5 cycles.
- Bytes 00 FF then A5 00 00 -> leading bytes ignored; DONE with zero writes (checksum build: byte 00 required).
- Length 16'h8001 with ADDR_WIDTH=16 -> ERR; load_err=1; tx 15; no writes.
- A5 00 01 12, then no byte for TIMEOUT_CYCLES (set to 100) -> ERR at cycle 100; cpu_hold stays 1.
- PROG_LOAD_CHECKSUM_EN: A5 00 01 12 34 + checksum 8'h27 -> DONE; same frame with checksum 8'h00 -> write occurs, then ERR and NAK.

Source files
------------

// File: rtl/prog_load_pkg.sv
// prog_load_pkg: shared types and constants for the program loader.
// Optional checksum support is enabled with `define PROG_LOAD_CHECKSUM_EN.
package prog_load_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHK,
        DONE,
        ERR
    } state_t;

    localparam logic [7:0] ACK_BYTE          = 8'h06;
    localparam logic [7:0] NAK_BYTE          = 8'h15;
    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    // States inside a frame, where the inter-byte idle timer runs
    function automatic logic in_frame(input state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA_HI) ||
               (s == DATA_LO) || (s == CHK);
    endfunction

endpackage

// File: rtl/prog_load_timeout.sv
// prog_load_timeout: inter-byte idle counter. Clears on clr or when disabled,
// counts while enabled and flags expiry after TIMEOUT_CYCLES-1 idle clocks.
module prog_load_timeout
    import prog_load_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Idle counter, saturating at LAST
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/prog_load_ctrl.sv
// prog_load_ctrl: boot loader filling program memory from the SPART byte
// stream. Frame: SYNC, LEN_HI, LEN_LO, N x {DATA_HI, DATA_LO} [, CHK].
// Define PROG_LOAD_CHECKSUM_EN to require a trailing XOR checksum byte.
module prog_load_ctrl
    import prog_load_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
    parameter logic [7:0]             SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int unsigned            TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_req,
    input  logic                  tx_rdy,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    output logic                  mem_we,
    output logic                  cpu_hold,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH-1:0] words_loaded
);

    // Largest word count that fits between BASE_ADDR and the top of memory
    localparam longint unsigned MAX_WORDS =
        (64'd1 << (ADDR_WIDTH - 1)) - (64'(BASE_ADDR) >> 1);

`ifdef PROG_LOAD_CHECKSUM_EN
    localparam state_t END_STATE = CHK;
`else
    localparam state_t END_STATE = DONE;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len_hi;
    logic [7:0]  data_hi;
    logic [15:0] words_rem;
    logic [15:0] len_word;
    logic        len_bad;
    logic        last_word;
    logic        is_sync;
    logic        tmo_expired;

`ifdef PROG_LOAD_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign len_word  = {len_hi, rx_data};
    assign len_bad   = 64'(len_word) > MAX_WORDS;
    assign last_word = (words_rem == 16'd1);
    assign is_sync   = (rx_data == SYNC_BYTE);

    prog_load_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (rx_valid),
        .en      (in_frame(state)),
        .expired (tmo_expired)
    );

    // Next-state decode; a received byte always takes priority over timeout
    always_comb begin
        state_nxt = state;
        if (rx_valid) begin
            case (state)
                IDLE, DONE, ERR: if (is_sync) state_nxt = LEN_HI;
                LEN_HI:  state_nxt = LEN_LO;
                LEN_LO: begin
                    if (len_bad)              state_nxt = ERR;
                    else if (len_word == '0)  state_nxt = END_STATE;
                    else                      state_nxt = DATA_HI;
                end
                DATA_HI: state_nxt = DATA_LO;
                DATA_LO: state_nxt = last_word ? END_STATE : DATA_HI;
`ifdef PROG_LOAD_CHECKSUM_EN
                CHK:     state_nxt = (rx_data == csum) ? DONE : ERR;
`else
                CHK:     state_nxt = ERR;
`endif
                default: state_nxt = IDLE;
            endcase
        end else if (in_frame(state) && tmo_expired) begin
            state_nxt = ERR;
        end
    end

    // FSM state, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            len_hi       <= '0;
            data_hi      <= '0;
            words_rem    <= '0;
            cpu_hold     <= 1'b1;
            mem_we       <= 1'b0;
            tx_req       <= 1'b0;
            tx_data      <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            mem_addr     <= BASE_ADDR;
            mem_wdata    <= '0;
        end else begin
            state  <= state_nxt;
            mem_we <= 1'b0;

            if (tx_req && tx_rdy) begin
                tx_req <= 1'b0;
            end

            if (rx_valid) begin
                case (state)
                    IDLE, DONE, ERR: begin
                        if (is_sync) begin
                            cpu_hold     <= 1'b1;
                            load_done    <= 1'b0;
                            load_err     <= 1'b0;
                            words_loaded <= '0;
                            mem_addr     <= BASE_ADDR;
                        end
                    end
                    LEN_HI:  len_hi    <= rx_data;
                    LEN_LO:  words_rem <= len_word;
                    DATA_HI: data_hi   <= rx_data;
                    DATA_LO: begin
                        mem_we       <= 1'b1;
                        mem_wdata    <= {data_hi, rx_data};
                        mem_addr     <= BASE_ADDR + {words_loaded[ADDR_WIDTH-2:0], 1'b0};
                        words_loaded <= words_loaded + 1'b1;
                        words_rem    <= words_rem - 1'b1;
                    end
                    default: ;
                endcase
            end

            // Status byte is queued on entry, overriding any stale handshake clear
            if (state_nxt == DONE && state != DONE) begin
                cpu_hold  <= 1'b0;
                load_done <= 1'b1;
                load_err  <= 1'b0;
                tx_req    <= 1'b1;
                tx_data   <= ACK_BYTE;
            end
            if (state_nxt == ERR && state != ERR) begin
                cpu_hold  <= 1'b1;
                load_done <= 1'b0;
                load_err  <= 1'b1;
                tx_req    <= 1'b1;
                tx_data   <= NAK_BYTE;
            end
        end
    end

`ifdef PROG_LOAD_CHECKSUM_EN
    // XOR accumulator over length and data bytes, cleared by SYNC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (rx_valid) begin
            case (state)
                IDLE, DONE, ERR: if (is_sync) csum <= '0;
                LEN_HI, LEN_LO, DATA_HI, DATA_LO: csum <= csum ^ rx_data;
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// tb_prog_load_ctrl: directed bench for prog_load_ctrl with write and tx
// scoreboards. Follows PROG_LOAD_CHECKSUM_EN when it is defined.
module tb_prog_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_req;
    logic        tx_rdy = 1'b1;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;
    logic [15:0] words_loaded;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] cnt;
    } wr_t;

    wr_t        wr_q[$];
    logic [7:0] tx_q[$];

    prog_load_ctrl #(
        .ADDR_WIDTH     (16),
        .BASE_ADDR      (16'h0000),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (100)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_req       (tx_req),
        .tx_rdy       (tx_rdy),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [15:0] a, input logic [15:0] d, input logic [15:0] c);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.cnt  = c;
        wr_q.push_back(e);
    endtask

    // Memory write monitor
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                chk("wr_data", 32'(mem_wdata), 32'(e.data));
                chk("wr_count", 32'(words_loaded), 32'(e.cnt));
            end
        end
    end

    // Status byte monitor: one byte per accepted handshake
    always @(negedge clk) begin
        if (rst_n && tx_req && tx_rdy) begin
            if (tx_q.size() == 0) begin
                chk("unexpected_tx", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
                chk("tx_byte", 32'(tx_data), 32'(tx_q.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(3);
        chk("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_tx_req", 32'(tx_req), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        chk("rst_err", 32'(load_err), 32'd0);
        chk("rst_words", 32'(words_loaded), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'h0000);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Reset in the middle of a frame, after one data byte
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
        chk("midrst_mem_we", 32'(mem_we), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // Leading junk ignored in IDLE, then zero-length frame
        send(8'h00); send(8'hFF);
        tick(1);
        chk("junk_done", 32'(load_done), 32'd0);
        chk("junk_hold", 32'(cpu_hold), 32'd1);
        chk("junk_tx", 32'(tx_req), 32'd0);
        tx_q.push_back(8'h06);
        send(8'hA5); send(8'h00); send(8'h00);
`ifdef PROG_LOAD_CHECKSUM_EN
        send(8'h00);
`endif
        chk("zero_done", 32'(load_done), 32'd1);
        chk("zero_hold", 32'(cpu_hold), 32'd0);
        chk("zero_words", 32'(words_loaded), 32'd0);
        tick(3);
        chk("zero_tx_drained", 32'(tx_q.size()), 32'd0);

        // Two-word frame, back-to-back bytes, delayed tx_rdy
        tx_rdy = 1'b0;
        push_wr(16'h0000, 16'h1234, 16'd1);
        push_wr(16'h0002, 16'hABCD, 16'd2);
        tx_q.push_back(8'h06);
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'h12); send(8'h34); send(8'hAB); send(8'hCD);
`ifdef PROG_LOAD_CHECKSUM_EN
        send(8'h42);
`endif
        tick(1);
        chk("two_done", 32'(load_done), 32'd1);
        chk("two_err", 32'(load_err), 32'd0);
        chk("two_hold", 32'(cpu_hold), 32'd0);
        chk("two_words", 32'(words_loaded), 32'd2);
        chk("two_wr_q", 32'(wr_q.size()), 32'd0);
        tick(4);
        chk("two_tx_held", 32'(tx_req), 32'd1);
        chk("two_tx_data", 32'(tx_data), 32'h06);
        tx_rdy = 1'b1;
        tick(1);
        chk("two_tx_cleared", 32'(tx_req), 32'd0);
        tick(3);
        chk("two_tx_once", 32'(tx_q.size()), 32'd0);

        // Restart from DONE with an oversize length
        send(8'hA5);
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done", 32'(load_done), 32'd0);
        chk("restart_words", 32'(words_loaded), 32'd0);
        chk("restart_addr", 32'(mem_addr), 32'h0000);
        tx_q.push_back(8'h15);
        send(8'h80); send(8'h01);
        chk("len_err", 32'(load_err), 32'd1);
        chk("len_done", 32'(load_done), 32'd0);
        chk("len_hold", 32'(cpu_hold), 32'd1);
        tick(3);
        chk("len_tx_drained", 32'(tx_q.size()), 32'd0);

        // Largest legal length is accepted (frame then abandoned by reset)
        send(8'hA5); send(8'h80); send(8'h00);
        tick(1);
        chk("maxlen_err", 32'(load_err), 32'd0);
        chk("maxlen_tx", 32'(tx_req), 32'd0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);

        // Inter-byte timeout
        send(8'hA5); send(8'h00); send(8'h01);
        tx_q.push_back(8'h15);
        send(8'h12);
        tick(99);
        chk("tmo_before", 32'(load_err), 32'd0);
        tick(1);
        chk("tmo_at", 32'(load_err), 32'd1);
        chk("tmo_hold", 32'(cpu_hold), 32'd1);
        tick(3);
        chk("tmo_tx_drained", 32'(tx_q.size()), 32'd0);

`ifdef PROG_LOAD_CHECKSUM_EN
        // Checksum match and mismatch
        push_wr(16'h0000, 16'h1234, 16'd1);
        tx_q.push_back(8'h06);
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h27);
        chk("csum_ok_done", 32'(load_done), 32'd1);
        chk("csum_ok_hold", 32'(cpu_hold), 32'd0);
        tick(3);
        push_wr(16'h0000, 16'h1234, 16'd1);
        tx_q.push_back(8'h15);
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h00);
        chk("csum_bad_err", 32'(load_err), 32'd1);
        chk("csum_bad_hold", 32'(cpu_hold), 32'd1);
        tick(3);
`endif

        chk("final_wr_q", 32'(wr_q.size()), 32'd0);
        chk("final_tx_q", 32'(tx_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
